// File: rtl/ifmap_pkg.sv
// ifmap_pkg: shared bank count, padding-bank set and scheduler FSM states
package ifmap_pkg;

    localparam int BANKS = 8;
    localparam int PAD_BANK_LIST [4] = '{0, 1, 6, 7};
    localparam logic [7:0] PAD_MASK = 8'b1100_0011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KICK,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/ifbank_wr_mux.sv
// ifbank_wr_mux: registered per-bank write mux, padding wins over loader
module ifbank_wr_mux #(
    parameter int AW = 11,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pd_req,
    input  logic          pd_wen,
    input  logic [AW-1:0] pd_addr,
    input  logic [DW-1:0] pd_data,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          cen,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // idle cycles deassert the enables but keep addr/data stable for the macro
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cen  <= 1'b1;
            wen  <= 1'b1;
            addr <= '0;
            data <= '0;
        end else if (pd_req) begin
            cen  <= 1'b0;
            wen  <= pd_wen;
            addr <= pd_addr;
            data <= pd_data;
        end else if (ld_req) begin
            cen  <= 1'b0;
            wen  <= 1'b0;
            addr <= ld_addr;
            data <= ld_data;
        end else begin
            cen  <= 1'b1;
            wen  <= 1'b1;
        end
    end

endmodule

// File: rtl/ifsram_wr_sched.sv
// ifsram_wr_sched: per-tile scheduler sharing the ifmap banks between padding and loader
module ifsram_wr_sched
    import ifmap_pkg::*;
#(
    parameter int IFMAP_SRAM_ADDBITS    = 11,
    parameter int IFMAP_SRAM_DATA_WIDTH = 64,
    parameter int BANKS                 = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   tile_start,
    input  logic                                   cfg_pad_en,
    output logic                                   tile_busy,
    output logic                                   tile_done,
    output logic                                   if_pad_start,
    input  logic                                   if_pad_busy,
    input  logic                                   if_pad_done,
    input  logic                                   pdb0_cen,
    input  logic                                   pdb0_wen,
    input  logic [IFMAP_SRAM_ADDBITS-1:0]          pdb0_addr,
    input  logic                                   pdb1_cen,
    input  logic                                   pdb1_wen,
    input  logic [IFMAP_SRAM_ADDBITS-1:0]          pdb1_addr,
    input  logic                                   pdb6_cen,
    input  logic                                   pdb6_wen,
    input  logic [IFMAP_SRAM_ADDBITS-1:0]          pdb6_addr,
    input  logic                                   pdb7_cen,
    input  logic                                   pdb7_wen,
    input  logic [IFMAP_SRAM_ADDBITS-1:0]          pdb7_addr,
    input  logic [IFMAP_SRAM_DATA_WIDTH-1:0]       pd_data,
    input  logic                                   ld_valid,
    output logic                                   ld_ready,
    input  logic [2:0]                             ld_bank,
    input  logic [IFMAP_SRAM_ADDBITS-1:0]          ld_addr,
    input  logic [IFMAP_SRAM_DATA_WIDTH-1:0]       ld_data,
    input  logic                                   ld_last,
    output logic [BANKS-1:0]                       sram_cen,
    output logic [BANKS-1:0]                       sram_wen,
    output logic [BANKS*IFMAP_SRAM_ADDBITS-1:0]    sram_addr,
    output logic [BANKS*IFMAP_SRAM_DATA_WIDTH-1:0] sram_data
);

    localparam int AW = IFMAP_SRAM_ADDBITS;
    localparam int DW = IFMAP_SRAM_DATA_WIDTH;

    state_t state, next;
    logic pad_fin, ld_fin, active, ld_acc;
    logic [BANKS-1:0] pd_req, pd_wen, ld_req;
    logic unused_busy;

    assign unused_busy = if_pad_busy;
    assign active = (state == S_KICK) || (state == S_RUN);
    assign pd_req = PAD_MASK & {~pdb7_cen, ~pdb6_cen, 4'b0000, ~pdb1_cen, ~pdb0_cen};
    assign pd_wen = {pdb7_wen, pdb6_wen, 4'b1111, pdb1_wen, pdb0_wen};
    assign ld_acc = ld_valid && ld_ready;
    assign ld_req = {BANKS{ld_acc}} & (BANKS'(1) << ld_bank);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    // completion flags: cleared on tile acceptance, sticky while the tile runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_fin <= 1'b0;
            ld_fin  <= 1'b0;
        end else if (state == S_IDLE && tile_start) begin
            pad_fin <= !cfg_pad_en;
            ld_fin  <= 1'b0;
        end else if (active) begin
            pad_fin <= pad_fin || if_pad_done;
            ld_fin  <= ld_fin || (ld_acc && ld_last);
        end
    end

    // next state and state-decoded outputs; loader stalls only on a padding hit to its bank
    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  next = tile_start ? (cfg_pad_en ? S_KICK : S_RUN) : S_IDLE;
            S_KICK:  next = S_RUN;
            S_RUN:   next = (pad_fin && ld_fin) ? S_DONE : S_RUN;
            default: next = S_IDLE;
        endcase
        tile_busy    = state != S_IDLE;
        tile_done    = state == S_DONE;
        if_pad_start = state == S_KICK;
        ld_ready     = active && !ld_fin && !pd_req[ld_bank];
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [AW-1:0] pa;
        assign pa = b == 0 ? pdb0_addr :
                    b == 1 ? pdb1_addr :
                    b == 6 ? pdb6_addr :
                    b == 7 ? pdb7_addr : '0;
        ifbank_wr_mux #(.AW(AW), .DW(DW)) u_mux (
            .clk     (clk),
            .reset   (reset),
            .pd_req  (pd_req[b]),
            .pd_wen  (pd_wen[b]),
            .pd_addr (pa),
            .pd_data (pd_data),
            .ld_req  (ld_req[b]),
            .ld_addr (ld_addr),
            .ld_data (ld_data),
            .cen     (sram_cen[b]),
            .wen     (sram_wen[b]),
            .addr    (sram_addr[b*AW +: AW]),
            .data    (sram_data[b*DW +: DW])
        );
    end

endmodule

// File: tb/tb_ifsram_wr_sched.sv
// tb_ifsram_wr_sched: random stimulus against a timestamp-based tile model with a scoreboard
module tb_ifsram_wr_sched;

    localparam int AW  = 11;
    localparam int DW  = 64;
    localparam int NB  = 8;
    localparam int INF = 1 << 30;
    localparam int PB [4] = '{0, 1, 6, 7};

    typedef struct {
        logic              ready;
        logic              busy;
        logic              done;
        logic              kick;
        logic [NB-1:0]     cen;
        logic [NB-1:0]     wen;
        logic [NB*AW-1:0]  addr;
        logic [NB*DW-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tile_start = 1'b0, cfg_pad_en = 1'b0, if_pad_busy = 1'b0, if_pad_done = 1'b0;
    logic [3:0] pcen = 4'hF, pwen = 4'hF;
    logic [AW-1:0] paddr [4];
    logic [DW-1:0] pd_data = '0;
    logic ld_valid = 1'b0, ld_last = 1'b0;
    logic [2:0] ld_bank = 3'd0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic tile_busy, tile_done, if_pad_start, ld_ready;
    logic [NB-1:0] sram_cen, sram_wen;
    logic [NB*AW-1:0] sram_addr;
    logic [NB*DW-1:0] sram_data;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    int cyc, t0, tp, tl, dc;
    bit pad_en;
    logic [NB-1:0] m_cen, m_wen;
    logic [NB*AW-1:0] m_addr;
    logic [NB*DW-1:0] m_data;

    ifsram_wr_sched dut (
        .clk(clk), .reset(reset), .tile_start(tile_start), .cfg_pad_en(cfg_pad_en),
        .tile_busy(tile_busy), .tile_done(tile_done), .if_pad_start(if_pad_start),
        .if_pad_busy(if_pad_busy), .if_pad_done(if_pad_done),
        .pdb0_cen(pcen[0]), .pdb0_wen(pwen[0]), .pdb0_addr(paddr[0]),
        .pdb1_cen(pcen[1]), .pdb1_wen(pwen[1]), .pdb1_addr(paddr[1]),
        .pdb6_cen(pcen[2]), .pdb6_wen(pwen[2]), .pdb6_addr(paddr[2]),
        .pdb7_cen(pcen[3]), .pdb7_wen(pwen[3]), .pdb7_addr(paddr[3]),
        .pd_data(pd_data), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_bank(ld_bank),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_data(sram_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [NB*DW-1:0] act, input logic [NB*DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    task automatic model_reset();
        t0 = -100; tp = INF; tl = INF; dc = -1; pad_en = 0;
        m_cen = '1; m_wen = '1; m_addr = '0; m_data = '0;
    endtask

    // Expected outputs for the current cycle, then the effect of this cycle's inputs.
    task automatic step();
        exp_t e;
        bit idle, coll, acc;
        int rf, mx;
        idle = cyc > dc;
        coll = 0;
        for (int i = 0; i < 4; i++) if (PB[i] == int'(ld_bank) && !pcen[i]) coll = 1;
        e.ready = !idle && cyc < dc && cyc < tl && !coll;
        e.busy  = !idle;
        e.done  = cyc == dc;
        e.kick  = !idle && pad_en && cyc == t0 + 1;
        e.cen = m_cen; e.wen = m_wen; e.addr = m_addr; e.data = m_data;
        q.push_back(e);
        acc = ld_valid && e.ready;
        m_cen = '1;
        m_wen = '1;
        for (int i = 0; i < 4; i++) if (!pcen[i]) begin
            m_cen[PB[i]] = 1'b0;
            m_wen[PB[i]] = pwen[i];
            m_addr[PB[i]*AW +: AW] = paddr[i];
            m_data[PB[i]*DW +: DW] = pd_data;
        end
        if (acc) begin
            m_cen[ld_bank] = 1'b0;
            m_wen[ld_bank] = 1'b0;
            m_addr[int'(ld_bank)*AW +: AW] = ld_addr;
            m_data[int'(ld_bank)*DW +: DW] = ld_data;
        end
        if (!idle && cyc < dc) begin
            if (if_pad_done && tp == INF) tp = cyc + 1;
            if (acc && ld_last && tl == INF) tl = cyc + 1;
        end
        if (idle && tile_start) begin
            t0 = cyc; pad_en = cfg_pad_en; tp = cfg_pad_en ? INF : cyc + 1; tl = INF; dc = INF;
        end
        if (tp != INF && tl != INF && dc == INF) begin
            rf = t0 + (pad_en ? 2 : 1);
            mx = tp > tl ? tp : tl;
            mx = mx > rf ? mx : rf;
            dc = mx + 1;
        end
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ld_ready", NB*DW'(ld_ready), NB*DW'(e.ready));
                chk("tile_busy", NB*DW'(tile_busy), NB*DW'(e.busy));
                chk("tile_done", NB*DW'(tile_done), NB*DW'(e.done));
                chk("if_pad_start", NB*DW'(if_pad_start), NB*DW'(e.kick));
                chk("sram_cen", NB*DW'(sram_cen), NB*DW'(e.cen));
                chk("sram_wen", NB*DW'(sram_wen), NB*DW'(e.wen));
                chk("sram_addr", NB*DW'(sram_addr), NB*DW'(e.addr));
                chk("sram_data", sram_data, e.data);
            end
        end
    end

    initial begin : driver
        bit hold;
        for (int i = 0; i < 4; i++) paddr[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cen", NB*DW'(sram_cen), NB*DW'(8'hFF));
        chk("rst_wen", NB*DW'(sram_wen), NB*DW'(8'hFF));
        chk("rst_addr", NB*DW'(sram_addr), '0);
        chk("rst_data", sram_data, '0);
        chk("rst_busy", NB*DW'(tile_busy), '0);
        chk("rst_done", NB*DW'(tile_done), '0);
        chk("rst_kick", NB*DW'(if_pad_start), '0);
        chk("rst_ready", NB*DW'(ld_ready), '0);
        model_reset();
        cyc = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                @(negedge clk);
                #2;
                reset = 1'b1;
                #1;
                chk("async_rst_cen", NB*DW'(sram_cen), NB*DW'(8'hFF));
                chk("async_rst_busy", NB*DW'(tile_busy), '0);
                chk("async_rst_ready", NB*DW'(ld_ready), '0);
                model_reset();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else if (k > 0) begin
                @(posedge clk);
                #1;
            end
            hold = k >= 1490 && k < 1500;
            tile_start  = ($urandom_range(0, 7) == 0) || (k >= 1490 && k < 1493);
            cfg_pad_en  = 1'($urandom_range(0, 1));
            if_pad_busy = 1'($urandom_range(0, 1));
            if_pad_done = ($urandom_range(0, 9) == 0) && !hold;
            for (int i = 0; i < 4; i++) begin
                pcen[i]  = $urandom_range(0, 9) >= 3;
                pwen[i]  = $urandom_range(0, 4) == 0;
                paddr[i] = AW'($urandom);
            end
            pd_data  = {$urandom, $urandom};
            ld_valid = $urandom_range(0, 3) != 0;
            ld_bank  = 3'($urandom);
            ld_addr  = AW'($urandom);
            ld_data  = {$urandom, $urandom};
            ld_last  = ($urandom_range(0, 7) == 0) && !hold;
            step();
        end
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifsram_wr_sched.md
# ifsram_wr_sched

Tile-level write scheduler for the eight ifmap SRAM banks. On each tile it kicks the padding writer, `ifsram_pd`, and lets the ifmap loader stream into the banks at the same time. It gives padding writes fixed priority on banks 0, 1, 6 and 7 and back-pressures the loader only on a same-bank collision. It sits between the loader, the padding writer and the bank macros, and reports tile completion to the layer controller.

## Interface
Parameters:
- `IFMAP_SRAM_ADDBITS`, 11, bank address width.
- `IFMAP_SRAM_DATA_WIDTH`, 64, bank data width.
- `BANKS`, 8, number of ifmap banks; fixed at 8.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tile_start`  in  1  one-cycle request to begin a tile; ignored while `tile_busy`.
- `cfg_pad_en`  in  1  sampled with `tile_start`; 1 = this tile needs padding.
- `tile_busy`  out  1  high from the cycle after accepted `tile_start` through S_DONE.
- `tile_done`  out  1  one-cycle pulse, issued in S_DONE.
- `if_pad_start`  out  1  one-cycle kick to the padding writer.
- `if_pad_busy`  in  1  padding writer busy; informational only.
- `if_pad_done`  in  1  padding writer done pulse.
- `pdb{0,1,6,7}_cen`, `pdb{0,1,6,7}_wen`  in  1 each  padding bank enables, active low.
- `pdb{0,1,6,7}_addr`  in  IFMAP_SRAM_ADDBITS each  padding bank addresses.
- `pd_data`  in  IFMAP_SRAM_DATA_WIDTH  padding write data.
- `ld_valid`  in  1  loader beat valid.
- `ld_ready`  out  1  loader beat accepted when `ld_valid & ld_ready`.
- `ld_bank`  in  3  target bank of the beat.
- `ld_addr`  in  IFMAP_SRAM_ADDBITS  beat address.
- `ld_data`  in  IFMAP_SRAM_DATA_WIDTH  beat data.
- `ld_last`  in  1  final beat of the tile.
- `sram_cen`, `sram_wen`  out  BANKS  per-bank enables, active low, registered.
- `sram_addr`  out  BANKS*IFMAP_SRAM_ADDBITS  bank b occupies bits [b*ADDBITS +: ADDBITS], registered.
- `sram_data`  out  BANKS*IFMAP_SRAM_DATA_WIDTH  bank b occupies bits [b*DW +: DW], registered.

## Operation
- FSM states: S_IDLE, S_KICK, S_RUN, S_DONE.
- **S_IDLE.** On `tile_start`:
  - clear `pad_fin` and `ld_fin`;
  - if `cfg_pad_en`, go to S_KICK;
  - otherwise set `pad_fin`=1 and go to S_RUN.
- **S_KICK.** Assert `if_pad_start` for exactly this one cycle, then go to S_RUN.
- **S_RUN.** Go to S_DONE in the cycle after both `pad_fin` and `ld_fin` are 1.
- **S_DONE.** Assert `tile_done`, then go to S_IDLE.
- **`pad_fin`** is set by `if_pad_done` in S_KICK or S_RUN.
- **`ld_fin`** is set by an accepted beat with `ld_last`=1.
- **Simultaneous finish:** `pad_fin` and `ld_fin` may set in the same cycle; S_DONE still follows one cycle later.
- **Padding requests:** a padding bank is requesting when its `pdbX_cen`=0.
- **Padding priority:** padding requests are passed through in every state and always win their bank.
- **`ld_ready`** = (state is S_KICK or S_RUN) & !`ld_fin` & !(`ld_bank` is in {0,1,6,7} and that bank's `pdbX_cen`=0).
- **Loader is combinational to the pad inputs:** `ld_ready` depends only on current-cycle inputs and state.
- **Parallel access:** the loader and padding may write different banks in the same cycle. Several padding banks may be active in the same cycle.
- **Bank mux, per bank b:**
  - a padding request selects the padding cen/wen/addr and `pd_data`;
  - else an accepted loader beat with `ld_bank`=b drives cen=0, wen=0, `ld_addr`, `ld_data`;
  - else cen=1, wen=1, and addr/data hold their previous values.
- **Banks 2–5** are never padding targets and take only loader beats.
- **Stray padding inputs:** `if_pad_done` outside S_KICK/S_RUN is ignored.

## Timing
- **Reset values:**
  - `sram_cen`, `sram_wen` all 1;
  - `sram_addr`, `sram_data` all 0;
  - `tile_busy`, `tile_done`, `if_pad_start` 0;
  - FSM in S_IDLE, both flags 0.
  - `ld_ready` is 0 in reset because it is decoded from the reset state.
- **Latency:** bank outputs appear exactly 1 cycle after the padding request or accepted beat. Address/data alignment with cen is preserved.
- **`tile_start` to `if_pad_start`:** `if_pad_start` rises 1 cycle after `tile_start`. `ld_ready` may rise in that same cycle.
- **Minimum tile length:** with no padding and a single-beat `ld_last` in the first S_RUN cycle, `tile_done` comes 3 cycles after `tile_start`.
- **Reset mid-tile:** all registers return to reset values immediately. In-flight writes are dropped, and the next tile needs a fresh `tile_start`.

## Structure
- **Shared package `ifmap_pkg`:** FSM state encodings, `BANKS`=8, and the pad-bank list {0,1,6,7}. `ifsram_pd` imports the same list.
- **Sub-module `ifbank_wr_mux`:** one per bank, holding the registered 2:1 priority mux. It is instantiated 8 times; banks 2–5 tie the padding request input to 0.

## Test plan
- **No padding:** `tile_start` with `cfg_pad_en`=0, then 4 loader beats to bank 3 at addr 0..3, the last with `ld_last`. Expect:
  - `if_pad_start` never asserts;
  - `sram_cen[3]`=0 for 4 cycles, each 1 cycle after its beat;
  - `tile_done` pulses once.
- **Padding only:** `cfg_pad_en`=1 and a `pdb7` burst at addr 44..47. Expect:
  - a one-cycle `if_pad_start` pulse;
  - `sram_addr[7]` reproduces 44..47 one cycle late with `pd_data`=0;
  - no `tile_done` until `ld_last` is also accepted.
- **Collision:** `pdb0_cen`=0 while a loader beat targets bank 0. Expect:
  - `ld_ready`=0 that cycle;
  - the bank 0 write carries the padding addr;
  - the loader beat lands on the first cycle `pdb0_cen` returns to 1.
- **No collision:** `pdb6` active while the loader writes bank 2. Expect both writes in the same cycle and `ld_ready`=1.
- **Simultaneous finish:** `if_pad_done` and `ld_last` accepted in the same cycle. Expect `tile_done` exactly 2 cycles later, and a `tile_start` while busy is ignored.
- **Async reset mid-tile:** assert `reset` asynchronously in S_RUN. Expect all `sram_cen`=1 and `tile_busy`=0 before the next clock edge.
